// File: rtl/dbg_bus_arbiter_pkg.sv
// Shared types and constants for the two-master debug/core bus arbiter.
// State encoding is one-hot, matching the rest of the debug logic.
package dbg_bus_arbiter_pkg;

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] REQ  = 3'b010;
    localparam logic [2:0] RSP  = 3'b100;

    typedef enum logic [2:0] {
        StIdle = IDLE,
        StReq  = REQ,
        StRsp  = RSP
    } state_e;

    localparam int unsigned M_CORE             = 0;
    localparam int unsigned M_DBG              = 1;
    localparam int unsigned NumMasters         = 2;
    localparam int unsigned StarveLimitDefault = 4;
    localparam int unsigned CntW               = 4;

    function automatic logic [CntW-1:0] sat_inc(logic [CntW-1:0] v, logic [CntW-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/dbg_bus_arbiter_if.sv
// One valid/ready request + response bus port. The master modport drives requests;
// the slave modport accepts them and returns responses.
interface dbg_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic            we;
    logic [DW/8-1:0] sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rdata;

    modport master (
        output req_valid, addr, wdata, we, sel, rsp_ready,
        input  req_ready, rsp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wdata, we, sel, rsp_ready,
        output req_ready, rsp_valid, rdata
    );

endinterface

// File: rtl/dbg_bus_arb_prio.sv
// Winner selection (debug first) with a saturating starvation counter that
// forces a core grant once the debug master has won STARVE_LIMIT times in a row.
module dbg_bus_arb_prio
    import dbg_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NumMasters-1:0] req_i,
    input  logic                  grant_en_i,
    output logic [NumMasters-1:0] win_o
);

    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            force_core;

    assign force_core = (cnt_q == Limit) && req_i[M_CORE];

    always_comb begin
        win_o = '0;
        if (req_i[M_DBG] && !force_core) begin
            win_o[M_DBG] = 1'b1;
        end else if (req_i[M_CORE]) begin
            win_o[M_CORE] = 1'b1;
        end
    end

    // Counter only moves when a grant is actually issued.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_en_i && (win_o != '0)) begin
            if (win_o[M_DBG] && req_i[M_CORE]) begin
                cnt_d = sat_inc(cnt_q, Limit);
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_bus_arbiter.sv
// Serialises core and debug system-bus transactions onto one slave port,
// exactly one outstanding at a time.
module dbg_bus_arbiter
    import dbg_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    dbg_bus_arbiter_if.slave  m0_io,
    dbg_bus_arbiter_if.slave  m1_io,
    dbg_bus_arbiter_if.master s_io,
    output logic [1:0]        grant_o
);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [1:0]      grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [DW/8-1:0] sel_q, sel_d;

    logic [NumMasters-1:0] req, win;
    logic                  in_idle, in_rsp, owner_rsp_ready;

    assign req     = {m1_io.req_valid, m0_io.req_valid};
    assign in_idle = (state_q == StIdle);
    assign in_rsp  = (state_q == StRsp);

    dbg_bus_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .grant_en_i (in_idle),
        .win_o      (win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (win != '0) begin
                    state_d = StReq;
                    owner_d = win[M_DBG];
                    grant_d = win;
                    addr_d  = win[M_DBG] ? m1_io.addr  : m0_io.addr;
                    wdata_d = win[M_DBG] ? m1_io.wdata : m0_io.wdata;
                    we_d    = win[M_DBG] ? m1_io.we    : m0_io.we;
                    sel_d   = win[M_DBG] ? m1_io.sel   : m0_io.sel;
                end
            end
            StReq: begin
                if (s_io.req_ready) state_d = StRsp;
            end
            StRsp: begin
                if (s_io.rsp_valid && s_io.rsp_ready) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
        end
    end

    assign m0_io.req_ready = in_idle & win[M_CORE];
    assign m1_io.req_ready = in_idle & win[M_DBG];

    assign s_io.req_valid = (state_q == StReq);
    assign s_io.addr      = addr_q;
    assign s_io.wdata     = wdata_q;
    assign s_io.we        = we_q;
    assign s_io.sel       = sel_q;

    // Response path is a pass-through steered by the latched owner.
    assign owner_rsp_ready = owner_q ? m1_io.rsp_ready : m0_io.rsp_ready;
    assign s_io.rsp_ready  = in_rsp & owner_rsp_ready;
    assign m0_io.rsp_valid = in_rsp & ~owner_q & s_io.rsp_valid;
    assign m1_io.rsp_valid = in_rsp & owner_q & s_io.rsp_valid;
    assign m0_io.rdata     = (in_rsp & ~owner_q) ? s_io.rdata : '0;
    assign m1_io.rdata     = (in_rsp & owner_q) ? s_io.rdata : '0;

    assign grant_o = grant_q;

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Directed scenario bench for dbg_bus_arbiter with a simple one-cycle-latency slave.
module tb_dbg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_o;
    int         total = 0;
    int         bad   = 0;

    logic [31:0] slv_rdata = 32'h0;
    bit          req_hs, rsp_hs;

    dbg_bus_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    dbg_bus_arbiter_if #(.AW(32), .DW(32)) m1_if ();
    dbg_bus_arbiter_if #(.AW(32), .DW(32)) s_if ();

    dbg_bus_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0_io   (m0_if),
        .m1_io   (m1_if),
        .s_io    (s_if),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk_pt();
        @(negedge clk);
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    // Slave: answers one cycle after each accepted request, holds until handshake.
    initial begin
        s_if.rsp_valid = 1'b0;
        s_if.rdata     = '0;
        forever begin
            @(negedge clk);
            req_hs = s_if.req_valid && s_if.req_ready;
            rsp_hs = s_if.rsp_valid && s_if.rsp_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_if.rsp_valid = 1'b0;
            end else begin
                if (rsp_hs) s_if.rsp_valid = 1'b0;
                if (req_hs) begin
                    s_if.rsp_valid = 1'b1;
                    s_if.rdata     = slv_rdata;
                end
            end
        end
    end

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            chk_pt();
            if (grant_o === 2'b00) done = 1'b1;
            drive_pt();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s drain: grant_o=%b still busy after 12 cycles, want 00", name, grant_o);
        end
    endtask

    task automatic test_reset();
        chk_pt();
        total++;
        if ({grant_o, s_if.req_valid, s_if.rsp_ready, m0_if.req_ready, m1_if.req_ready}
            !== 6'b0) begin
            bad++;
            $display("FAIL reset ctrl: grant=%b sreqv=%b srspr=%b m0rdy=%b m1rdy=%b want all 0",
                     grant_o, s_if.req_valid, s_if.rsp_ready, m0_if.req_ready, m1_if.req_ready);
        end
        total++;
        if ({s_if.addr, s_if.wdata, s_if.we, s_if.sel} !== 69'b0) begin
            bad++;
            $display("FAIL reset payload: addr=%h wdata=%h we=%b sel=%h want 0",
                     s_if.addr, s_if.wdata, s_if.we, s_if.sel);
        end
        drive_pt();
        rst_n = 1'b1;
    endtask

    task automatic test_core_read();
        slv_rdata = 32'hDEADBEEF;
        m0_if.req_valid = 1'b1; m0_if.addr = 32'h1000; m0_if.wdata = '0;
        m0_if.we = 1'b0; m0_if.sel = 4'hF;
        chk_pt();
        total++;
        if ({m0_if.req_ready, m1_if.req_ready, grant_o} !== 4'b1000) begin
            bad++;
            $display("FAIL core_read accept: m0rdy=%b m1rdy=%b grant=%b want 1 0 00",
                     m0_if.req_ready, m1_if.req_ready, grant_o);
        end
        drive_pt();
        m0_if.req_valid = 1'b0;
        chk_pt();
        total++;
        if (s_if.req_valid !== 1'b1 || s_if.addr !== 32'h1000 || s_if.we !== 1'b0
            || grant_o !== 2'b01) begin
            bad++;
            $display("FAIL core_read req: sreqv=%b addr=%h we=%b grant=%b want 1 1000 0 01",
                     s_if.req_valid, s_if.addr, s_if.we, grant_o);
        end
        drive_pt();
        chk_pt();
        total++;
        if (m0_if.rsp_valid !== 1'b1 || m0_if.rdata !== 32'hDEADBEEF || m1_if.rsp_valid !== 1'b0
            || s_if.rsp_ready !== 1'b1 || grant_o !== 2'b01) begin
            bad++;
            $display("FAIL core_read rsp: m0v=%b rdata=%h m1v=%b srspr=%b grant=%b want 1 deadbeef 0 1 01",
                     m0_if.rsp_valid, m0_if.rdata, m1_if.rsp_valid, s_if.rsp_ready, grant_o);
        end
        drive_pt();
        chk_pt();
        total++;
        if (grant_o !== 2'b00 || m0_if.rsp_valid !== 1'b0 || s_if.req_valid !== 1'b0) begin
            bad++;
            $display("FAIL core_read idle: grant=%b m0v=%b sreqv=%b want 00 0 0",
                     grant_o, m0_if.rsp_valid, s_if.req_valid);
        end
        drive_pt();
    endtask

    task automatic test_simultaneous();
        slv_rdata = 32'h0;
        m0_if.req_valid = 1'b1; m0_if.addr = 32'h2000; m0_if.we = 1'b0; m0_if.sel = 4'hF;
        m1_if.req_valid = 1'b1; m1_if.addr = 32'h3000; m1_if.wdata = 32'h12345678;
        m1_if.we = 1'b1; m1_if.sel = 4'hF;
        chk_pt();
        total++;
        if ({m1_if.req_ready, m0_if.req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL simul first: m1rdy=%b m0rdy=%b want 1 0", m1_if.req_ready, m0_if.req_ready);
        end
        drive_pt();
        m1_if.req_valid = 1'b0;
        chk_pt();
        total++;
        if (grant_o !== 2'b10 || {s_if.addr, s_if.wdata, s_if.we, s_if.sel}
            !== {32'h3000, 32'h12345678, 1'b1, 4'hF} || m0_if.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL simul dbg_req: grant=%b addr=%h wdata=%h we=%b sel=%h m0rdy=%b want 10 3000 12345678 1 f 0",
                     grant_o, s_if.addr, s_if.wdata, s_if.we, s_if.sel, m0_if.req_ready);
        end
        drive_pt();
        chk_pt();
        total++;
        if ({m1_if.rsp_valid, m0_if.rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL simul dbg_rsp: m1v=%b m0v=%b want 1 0", m1_if.rsp_valid, m0_if.rsp_valid);
        end
        drive_pt();
        chk_pt();
        total++;
        if (m0_if.req_ready !== 1'b1 || grant_o !== 2'b00) begin
            bad++;
            $display("FAIL simul core_accept: m0rdy=%b grant=%b want 1 00", m0_if.req_ready, grant_o);
        end
        drive_pt();
        m0_if.req_valid = 1'b0;
        chk_pt();
        total++;
        if (grant_o !== 2'b01 || s_if.addr !== 32'h2000 || s_if.we !== 1'b0) begin
            bad++;
            $display("FAIL simul core_req: grant=%b addr=%h we=%b want 01 2000 0",
                     grant_o, s_if.addr, s_if.we);
        end
        drive_pt();
        chk_pt();
        total++;
        if (m0_if.rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL simul core_rsp: m0v=%b want 1", m0_if.rsp_valid);
        end
        drive_pt();
        drain("simul");
    endtask

    task automatic test_starvation();
        logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int n = 0;
        m0_if.req_valid = 1'b1; m0_if.addr = 32'h6000; m0_if.we = 1'b0;
        m1_if.req_valid = 1'b1; m1_if.addr = 32'h7000; m1_if.we = 1'b0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            chk_pt();
            if (m0_if.req_ready === 1'b1 || m1_if.req_ready === 1'b1) begin
                total++;
                if ({m1_if.req_ready, m0_if.req_ready} !== (exp_d[n] ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL starve grant%0d: m1rdy=%b m0rdy=%b want dbg=%b",
                             n, m1_if.req_ready, m0_if.req_ready, exp_d[n]);
                end
                n++;
            end
            drive_pt();
        end
        if (n < 10) begin
            total++; bad++;
            $display("FAIL starve timeout: grants=%0d want 10", n);
        end
        m0_if.req_valid = 1'b0;
        m1_if.req_valid = 1'b0;
        drain("starve");
    endtask

    task automatic test_slave_backpressure();
        s_if.req_ready = 1'b0;
        m0_if.req_valid = 1'b1; m0_if.addr = 32'h4000; m0_if.wdata = 32'hA5A5A5A5;
        m0_if.we = 1'b1; m0_if.sel = 4'h3;
        chk_pt();
        total++;
        if (m0_if.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp accept: m0rdy=%b want 1", m0_if.req_ready);
        end
        drive_pt();
        m0_if.req_valid = 1'b0;
        m1_if.req_valid = 1'b1; m1_if.addr = 32'h8000; m1_if.we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_pt();
            total++;
            if (s_if.req_valid !== 1'b1 || {s_if.addr, s_if.wdata, s_if.we, s_if.sel}
                !== {32'h4000, 32'hA5A5A5A5, 1'b1, 4'h3}) begin
                bad++;
                $display("FAIL bp payload c%0d: sreqv=%b addr=%h wdata=%h we=%b sel=%h want 1 4000 a5a5a5a5 1 3",
                         i, s_if.req_valid, s_if.addr, s_if.wdata, s_if.we, s_if.sel);
            end
            total++;
            if ({m0_if.req_ready, m1_if.req_ready, s_if.rsp_ready} !== 3'b000) begin
                bad++;
                $display("FAIL bp ready c%0d: m0rdy=%b m1rdy=%b srspr=%b want 0 0 0",
                         i, m0_if.req_ready, m1_if.req_ready, s_if.rsp_ready);
            end
            drive_pt();
        end
        m1_if.req_valid = 1'b0;
        s_if.req_ready  = 1'b1;
        drain("bp");
    endtask

    task automatic test_rsp_backpressure();
        slv_rdata = 32'hCAFEF00D;
        m1_if.rsp_ready = 1'b0;
        m1_if.req_valid = 1'b1; m1_if.addr = 32'h5000; m1_if.we = 1'b0; m1_if.sel = 4'hF;
        chk_pt();
        total++;
        if (m1_if.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rspbp accept: m1rdy=%b want 1", m1_if.req_ready);
        end
        drive_pt();
        m1_if.req_valid = 1'b0;
        chk_pt();
        drive_pt();
        for (int i = 0; i < 3; i++) begin
            chk_pt();
            total++;
            if (m1_if.rsp_valid !== 1'b1 || s_if.rsp_ready !== 1'b0 || m1_if.rdata !== 32'hCAFEF00D
                || grant_o !== 2'b10 || m0_if.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rspbp hold c%0d: m1v=%b srspr=%b rdata=%h grant=%b m0v=%b want 1 0 cafef00d 10 0",
                         i, m1_if.rsp_valid, s_if.rsp_ready, m1_if.rdata, grant_o, m0_if.rsp_valid);
            end
            drive_pt();
        end
        m1_if.rsp_ready = 1'b1;
        chk_pt();
        total++;
        if ({s_if.rsp_ready, m1_if.rsp_valid} !== 2'b11) begin
            bad++;
            $display("FAIL rspbp release: srspr=%b m1v=%b want 1 1", s_if.rsp_ready, m1_if.rsp_valid);
        end
        drive_pt();
        chk_pt();
        total++;
        if (grant_o !== 2'b00 || m1_if.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rspbp done: grant=%b m1v=%b want 00 0", grant_o, m1_if.rsp_valid);
        end
        drive_pt();
    endtask

    task automatic test_reset_mid();
        logic exp_d [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int  n = 0;
        bit  seen = 1'b0;
        m0_if.req_valid = 1'b1; m0_if.addr = 32'h9000; m0_if.we = 1'b0;
        m1_if.req_valid = 1'b1; m1_if.addr = 32'hA000; m1_if.we = 1'b0;
        // Three debug grants leave the starvation counter non-zero.
        for (int c = 0; c < 40 && n < 3; c++) begin
            chk_pt();
            if (m1_if.req_ready === 1'b1 || m0_if.req_ready === 1'b1) n++;
            drive_pt();
        end
        m0_if.req_valid = 1'b0;
        m1_if.req_valid = 1'b0;
        m1_if.rsp_ready = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            chk_pt();
            if (m1_if.rsp_valid === 1'b1) seen = 1'b1;
            if (!seen) drive_pt();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rstmid reach_rsp: m1 rsp_valid never seen, want 1");
        end
        drive_pt();
        rst_n = 1'b0;
        #1;
        total++;
        if ({grant_o, s_if.req_valid, s_if.rsp_ready, m0_if.req_ready, m1_if.req_ready,
             m0_if.rsp_valid, m1_if.rsp_valid} !== 8'b0) begin
            bad++;
            $display("FAIL rstmid async: grant=%b sreqv=%b srspr=%b m0rdy=%b m1rdy=%b m0v=%b m1v=%b want all 0",
                     grant_o, s_if.req_valid, s_if.rsp_ready, m0_if.req_ready, m1_if.req_ready,
                     m0_if.rsp_valid, m1_if.rsp_valid);
        end
        total++;
        if ({s_if.addr, s_if.we} !== 33'b0) begin
            bad++;
            $display("FAIL rstmid payload: addr=%h we=%b want 0 0", s_if.addr, s_if.we);
        end
        drive_pt();
        #2;
        rst_n = 1'b1;
        m1_if.rsp_ready = 1'b1;
        m0_if.req_valid = 1'b1;
        m1_if.req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            chk_pt();
            if (m0_if.req_ready === 1'b1 || m1_if.req_ready === 1'b1) begin
                total++;
                if ({m1_if.req_ready, m0_if.req_ready} !== (exp_d[n] ? 2'b10 : 2'b01)) begin
                    bad++;
                    $display("FAIL rstmid grant%0d: m1rdy=%b m0rdy=%b want dbg=%b",
                             n, m1_if.req_ready, m0_if.req_ready, exp_d[n]);
                end
                n++;
            end
            drive_pt();
        end
        if (n < 5) begin
            total++; bad++;
            $display("FAIL rstmid timeout: grants=%0d want 5", n);
        end
        m0_if.req_valid = 1'b0;
        m1_if.req_valid = 1'b0;
        drain("rstmid");
    endtask

    initial begin
        rst_n = 1'b0;
        m0_if.req_valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.we = 1'b0;
        m0_if.sel = '0; m0_if.rsp_ready = 1'b1;
        m1_if.req_valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.we = 1'b0;
        m1_if.sel = '0; m1_if.rsp_ready = 1'b1;
        s_if.req_ready = 1'b1;

        test_reset();
        test_core_read();
        test_simultaneous();
        test_starvation();
        test_slave_backpressure();
        test_rsp_backpressure();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
